// File: rtl/connect_pkg.sv
// Shared definitions for the CONNECT send-port scheduler.
// Holds the network-facing widths, the flit and credit field layouts,
// the packed flit typedefs and the scheduler state encoding.
package connect_pkg;

    localparam int NUM_VCS             = 2;
    localparam int FLIT_DATA_WIDTH     = 40;
    localparam int NUM_USER_RECV_PORTS = 4;
    localparam int BUF_DEPTH           = 4;

    localparam int VC_BITS    = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
    localparam int DEST_BITS  = $clog2(NUM_USER_RECV_PORTS);
    localparam int FLIT_W     = 2 + FLIT_DATA_WIDTH + DEST_BITS + VC_BITS;
    localparam int REQ_FLIT_W = FLIT_W - 1;
    localparam int CREDIT_W   = $clog2(BUF_DEPTH + 1);

    // Bit offsets inside a full flit {valid, tail, dest, vc, data}
    localparam int DATA_LSB  = 0;
    localparam int VC_LSB    = FLIT_DATA_WIDTH;
    localparam int DEST_LSB  = VC_LSB + VC_BITS;
    localparam int TAIL_BIT  = DEST_LSB + DEST_BITS;
    localparam int VALID_BIT = TAIL_BIT + 1;

    // Bit offsets inside a credit word {valid, vc}
    localparam int CREDIT_VC_LSB    = 0;
    localparam int CREDIT_VALID_BIT = VC_BITS;

    typedef struct packed {
        logic                       tail;
        logic [DEST_BITS-1:0]       dest;
        logic [VC_BITS-1:0]         vc;
        logic [FLIT_DATA_WIDTH-1:0] data;
    } req_flit_t;

    typedef struct packed {
        logic                       valid;
        logic                       tail;
        logic [DEST_BITS-1:0]       dest;
        logic [VC_BITS-1:0]         vc;
        logic [FLIT_DATA_WIDTH-1:0] data;
    } flit_t;

    typedef struct packed {
        logic               valid;
        logic [VC_BITS-1:0] vc;
    } credit_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/connect_rr_arbiter.sv
// Combinational round-robin pick.
//   req         : one request bit per requester
//   ptr         : highest-priority index this cycle
//   grant       : one-hot grant (all zero when nothing requests)
//   grant_idx   : index of the granted requester
//   grant_valid : at least one request was granted
module connect_rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    // Scan from ptr upward with wrap; first hit wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!grant_valid && req[(int'(ptr) + k) % N]) begin
                grant_valid                  = 1'b1;
                grant_idx                    = IDX_W'((int'(ptr) + k) % N);
                grant[(int'(ptr) + k) % N]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/connect_send_scheduler.sv
// Packet-granular scheduler for one CONNECT network send port.
//   clock, reset  : clock and synchronous active-high reset
//   req_valid/req_flit/req_ready : per-requester flit handshake
//   send_flit_out/send_flit_en   : registered flit into putFlit
//   credit_in     : {valid, vc} credit return from getCredits
//   busy          : a packet lock is held
//   credit_err    : sticky, a credit was returned to a full counter
module connect_send_scheduler
    import connect_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*REQ_FLIT_W-1:0] req_flit,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [FLIT_W-1:0]             send_flit_out,
    output logic                          send_flit_en,
    input  logic [VC_BITS:0]              credit_in,
    output logic                          busy,
    output logic                          credit_err
);

    state_t               state_q,  state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     owner_q,  owner_d;
    logic [DEST_BITS-1:0] dest_q,   dest_d;
    logic [VC_BITS-1:0]   vc_q,     vc_d;
    logic [CREDIT_W-1:0]  credit_q [NUM_VCS];
    logic [CREDIT_W-1:0]  credit_d [NUM_VCS];
    flit_t                flit_out_q, flit_out_d;
    logic                 en_q,       en_d;
    logic                 err_q,      err_d;

    req_flit_t            req_flits [NUM_REQ];
    logic [NUM_REQ-1:0]   cand;
    logic [NUM_VCS-1:0]   vc_avail;
    logic [NUM_VCS-1:0]   credit_inc;
    logic [NUM_VCS-1:0]   credit_dec;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;
    logic                 accept;
    logic [IDX_W-1:0]     acc_idx;
    req_flit_t            acc_flit;
    logic [DEST_BITS-1:0] acc_dest;
    logic [VC_BITS-1:0]   acc_vc;
    credit_t              credit_w;

    assign credit_w = credit_t'(credit_in);

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_flits[gi] = req_flit[gi*REQ_FLIT_W +: REQ_FLIT_W];
            assign cand[gi]      = req_valid[gi] && vc_avail[req_flits[gi].vc];
        end
        for (gi = 0; gi < NUM_VCS; gi++) begin : g_vc
            assign vc_avail[gi]   = (credit_q[gi] != '0);
            assign credit_dec[gi] = accept && (acc_vc == VC_BITS'(gi));
            assign credit_inc[gi] = credit_w.valid && (credit_w.vc == VC_BITS'(gi));
        end
    endgenerate

    connect_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req         (cand),
        .ptr         (rr_ptr_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // Output process: ready is combinational on the current grantee/owner.
    always_comb begin : ready_comb
        req_ready = '0;
        if (!reset) begin
            if (state_q == ST_IDLE) begin
                req_ready = arb_valid ? arb_grant : '0;
            end else begin
                req_ready[owner_q] = req_valid[owner_q] && vc_avail[vc_q];
            end
        end
    end

    assign busy = (state_q == ST_LOCKED);

    // Body flits travel on the dest/vc latched from the head flit.
    always_comb begin : accept_comb
        accept   = |(req_valid & req_ready);
        acc_idx  = (state_q == ST_IDLE) ? arb_idx : owner_q;
        acc_flit = req_flits[acc_idx];
        acc_dest = (state_q == ST_IDLE) ? acc_flit.dest : dest_q;
        acc_vc   = (state_q == ST_IDLE) ? acc_flit.vc   : vc_q;
    end

    // Next-state process.
    always_comb begin : next_state_comb
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        dest_d   = dest_q;
        vc_d     = vc_q;
        if (accept) begin
            if (acc_flit.tail) begin
                state_d  = ST_IDLE;
                rr_ptr_d = next_idx(acc_idx);
            end else if (state_q == ST_IDLE) begin
                state_d = ST_LOCKED;
                owner_d = acc_idx;
                dest_d  = acc_flit.dest;
                vc_d    = acc_flit.vc;
            end
        end
    end

    always_comb begin : flit_out_comb
        flit_out_d = '0;
        en_d       = accept;
        if (accept) begin
            flit_out_d.valid = 1'b1;
            flit_out_d.tail  = acc_flit.tail;
            flit_out_d.dest  = acc_dest;
            flit_out_d.vc    = acc_vc;
            flit_out_d.data  = acc_flit.data;
        end
    end

    // A send and a return on the same VC cancel out; a lone return to a
    // full counter saturates and raises the sticky error.
    always_comb begin : credit_comb
        err_d = err_q;
        for (int v = 0; v < NUM_VCS; v++) begin
            credit_d[v] = credit_q[v];
            if (credit_inc[v] && !credit_dec[v]) begin
                if (credit_q[v] == CREDIT_W'(BUF_DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + 1'b1;
                end
            end else if (credit_dec[v] && !credit_inc[v]) begin
                credit_d[v] = credit_q[v] - 1'b1;
            end
        end
    end

    // State register process.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            dest_q     <= '0;
            vc_q       <= '0;
            flit_out_q <= '0;
            en_q       <= 1'b0;
            err_q      <= 1'b0;
            for (int v = 0; v < NUM_VCS; v++) begin
                credit_q[v] <= CREDIT_W'(BUF_DEPTH);
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            dest_q     <= dest_d;
            vc_q       <= vc_d;
            flit_out_q <= flit_out_d;
            en_q       <= en_d;
            err_q      <= err_d;
            for (int v = 0; v < NUM_VCS; v++) begin
                credit_q[v] <= credit_d[v];
            end
        end
    end

    assign send_flit_out = flit_out_q;
    assign send_flit_en  = en_q;
    assign credit_err    = err_q;

endmodule

// File: tb/tb_connect_send_scheduler.sv
// Directed bench for connect_send_scheduler with default parameters.
module tb_connect_send_scheduler;
    import connect_pkg::*;

    localparam int NR = 4;
    localparam int DW = FLIT_DATA_WIDTH;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [NR-1:0]            req_valid;
    logic [NR*REQ_FLIT_W-1:0] req_flit;
    logic [NR-1:0]            req_ready;
    logic [FLIT_W-1:0]        send_flit_out;
    logic                     send_flit_en;
    logic [VC_BITS:0]         credit_in;
    logic                     busy;
    logic                     credit_err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    connect_send_scheduler #(.NUM_REQ(NR)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_flit      (req_flit),
        .req_ready     (req_ready),
        .send_flit_out (send_flit_out),
        .send_flit_en  (send_flit_en),
        .credit_in     (credit_in),
        .busy          (busy),
        .credit_err    (credit_err)
    );

    always @(negedge clock) begin
        if (send_flit_en) $display("[TB] t=%0t sent flit %h", $time, send_flit_out);
    end

    function automatic logic [REQ_FLIT_W-1:0] mk(input logic tail, input logic [DEST_BITS-1:0] dest,
                                                 input logic [VC_BITS-1:0] vc, input logic [DW-1:0] data);
        return {tail, dest, vc, data};
    endfunction

    task automatic set_req(input int i, input logic v, input logic [REQ_FLIT_W-1:0] f);
        req_valid[i] = v;
        req_flit[i*REQ_FLIT_W +: REQ_FLIT_W] = f;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; req_flit = '0; credit_in = '0;
        repeat (3) tick();
        set_req(0, 1'b1, mk(1'b1, 2'd0, 1'b0, DW'(1)));
        #1;
        tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL rst_ready got %b exp 0000", req_ready); end
        tests_run++; if (send_flit_en !== 1'b0) begin tests_failed++; $display("FAIL rst_en got %b exp 0", send_flit_en); end
        tests_run++; if (send_flit_out !== '0) begin tests_failed++; $display("FAIL rst_out got %h exp 0", send_flit_out); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy got %b exp 0", busy); end
        tests_run++; if (dut.credit_q[0] !== CREDIT_W'(4)) begin tests_failed++; $display("FAIL rst_cred0 got %0d exp 4", dut.credit_q[0]); end
        tests_run++; if (dut.credit_q[1] !== CREDIT_W'(4)) begin tests_failed++; $display("FAIL rst_cred1 got %0d exp 4", dut.credit_q[1]); end
        tests_run++; if (credit_err !== 1'b0) begin tests_failed++; $display("FAIL rst_err got %b exp 0", credit_err); end
        set_req(0, 1'b0, '0);
        reset = 1'b0;
        tick();
        tests_run++; if (send_flit_en !== 1'b0) begin tests_failed++; $display("FAIL rst_post_en got %b exp 0", send_flit_en); end
    endtask

    task automatic test_two_flit();
        set_req(0, 1'b1, mk(1'b0, 2'd1, 1'b0, DW'(32'ha)));
        #1;
        tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL p2_ready0 got %b exp 0001", req_ready); end
        tick();
        tests_run++; if (send_flit_en !== 1'b1) begin tests_failed++; $display("FAIL p2_en0 got %b exp 1", send_flit_en); end
        tests_run++; if (send_flit_out !== {1'b1, mk(1'b0, 2'd1, 1'b0, DW'(32'ha))}) begin tests_failed++; $display("FAIL p2_out0 got %h exp %h", send_flit_out, {1'b1, mk(1'b0, 2'd1, 1'b0, DW'(32'ha))}); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL p2_busy got %b exp 1", busy); end
        set_req(0, 1'b1, mk(1'b1, 2'd1, 1'b0, DW'(32'hb)));
        #1;
        tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL p2_ready1 got %b exp 0001", req_ready); end
        tick();
        tests_run++; if (send_flit_out !== {1'b1, mk(1'b1, 2'd1, 1'b0, DW'(32'hb))}) begin tests_failed++; $display("FAIL p2_out1 got %h exp %h", send_flit_out, {1'b1, mk(1'b1, 2'd1, 1'b0, DW'(32'hb))}); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL p2_busy_end got %b exp 0", busy); end
        set_req(0, 1'b0, '0);
        tick();
        tests_run++; if (send_flit_en !== 1'b0 || send_flit_out !== '0) begin tests_failed++; $display("FAIL p2_idle_out got en=%b out=%h exp en=0 out=0", send_flit_en, send_flit_out); end
        tests_run++; if (dut.credit_q[0] !== CREDIT_W'(2)) begin tests_failed++; $display("FAIL p2_cred0 got %0d exp 2", dut.credit_q[0]); end
        tests_run++; if (dut.rr_ptr_q !== 2'd1) begin tests_failed++; $display("FAIL p2_rr got %0d exp 1", dut.rr_ptr_q); end
    endtask

    // Two 3-flit packets competing; body flits of req2 carry bogus dest/vc.
    task automatic test_no_interleave();
        int i1 = 0;
        int i2 = 0;
        logic [NR-1:0] rdy;
        logic [FLIT_W-1:0] exp_out;
        for (int k = 0; k < 6; k++) begin
            set_req(1, i1 < 3, mk(i1 == 2, 2'd3, 1'b0, DW'(32'h10 + i1)));
            if (i2 == 0) set_req(2, 1'b1, mk(1'b0, 2'd2, 1'b0, DW'(32'h20)));
            else         set_req(2, i2 < 3, mk(i2 == 2, 2'd0, 1'b1, DW'(32'h20 + i2)));
            credit_in = {1'b1, 1'b0};
            #1;
            rdy = req_ready;
            tests_run++; if (rdy !== ((k < 3) ? 4'b0010 : 4'b0100)) begin tests_failed++; $display("FAIL ni_ready k=%0d got %b exp %b", k, rdy, (k < 3) ? 4'b0010 : 4'b0100); end
            tests_run++; if (busy !== ((k % 3) != 0)) begin tests_failed++; $display("FAIL ni_busy k=%0d got %b exp %b", k, busy, (k % 3) != 0); end
            exp_out = (k < 3) ? {1'b1, mk(k == 2, 2'd3, 1'b0, DW'(32'h10 + k))}
                              : {1'b1, mk(k == 5, 2'd2, 1'b0, DW'(32'h20 + k - 3))};
            tick();
            if (rdy[1]) i1++;
            if (rdy[2]) i2++;
            tests_run++; if (send_flit_out !== exp_out) begin tests_failed++; $display("FAIL ni_out k=%0d got %h exp %h", k, send_flit_out, exp_out); end
        end
        set_req(1, 1'b0, '0);
        set_req(2, 1'b0, '0);
        credit_in = '0;
        tests_run++; if (dut.rr_ptr_q !== 2'd3) begin tests_failed++; $display("FAIL ni_rr got %0d exp 3", dut.rr_ptr_q); end
        tests_run++; if (dut.credit_q[0] !== CREDIT_W'(2)) begin tests_failed++; $display("FAIL ni_cred0 got %0d exp 2", dut.credit_q[0]); end
        tests_run++; if (dut.credit_q[1] !== CREDIT_W'(4)) begin tests_failed++; $display("FAIL ni_cred1 got %0d exp 4", dut.credit_q[1]); end
    endtask

    // req3 exhausts vc1 while req0 keeps sending on vc0.
    task automatic test_credit_block();
        int gseq [10] = '{3, 0, 3, 0, 3, 0, 3, 0, 0, 3};
        int n3 = 0;
        int e3 = 0;
        logic [NR-1:0] rdy;
        logic [FLIT_W-1:0] exp_out;
        for (int c = 0; c < 10; c++) begin
            set_req(0, 1'b1, mk(1'b1, 2'd0, 1'b0, DW'(32'ha0 + c)));
            set_req(3, n3 < 5, mk(1'b1, 2'd0, 1'b1, DW'(32'h30 + n3)));
            if (c == 8)             credit_in = {1'b1, 1'b1};
            else if (gseq[c] == 0)  credit_in = {1'b1, 1'b0};
            else                    credit_in = '0;
            #1;
            rdy = req_ready;
            tests_run++; if (rdy !== 4'(1 << gseq[c])) begin tests_failed++; $display("FAIL cb_ready c=%0d got %b exp %b", c, rdy, 4'(1 << gseq[c])); end
            if (gseq[c] == 0) exp_out = {1'b1, mk(1'b1, 2'd0, 1'b0, DW'(32'ha0 + c))};
            else              exp_out = {1'b1, mk(1'b1, 2'd0, 1'b1, DW'(32'h30 + e3))};
            if (gseq[c] == 3) e3++;
            tick();
            if (rdy[3]) n3++;
            tests_run++; if (send_flit_out !== exp_out) begin tests_failed++; $display("FAIL cb_out c=%0d got %h exp %h", c, send_flit_out, exp_out); end
            if (c == 7) begin
                tests_run++; if (dut.credit_q[1] !== CREDIT_W'(0)) begin tests_failed++; $display("FAIL cb_cred1_empty got %0d exp 0", dut.credit_q[1]); end
            end
        end
        set_req(0, 1'b0, '0);
        set_req(3, 1'b0, '0);
        credit_in = '0;
        tests_run++; if (dut.credit_q[1] !== CREDIT_W'(0)) begin tests_failed++; $display("FAIL cb_cred1 got %0d exp 0", dut.credit_q[1]); end
        tests_run++; if (dut.credit_q[0] !== CREDIT_W'(1)) begin tests_failed++; $display("FAIL cb_cred0 got %0d exp 1", dut.credit_q[0]); end
        tests_run++; if (dut.rr_ptr_q !== 2'd0) begin tests_failed++; $display("FAIL cb_rr got %0d exp 0", dut.rr_ptr_q); end
    endtask

    task automatic test_credit_edges();
        set_req(0, 1'b1, mk(1'b1, 2'd2, 1'b0, DW'(32'h55)));
        credit_in = {1'b1, 1'b0};
        #1;
        tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL ce_ready got %b exp 0001", req_ready); end
        tick();
        tests_run++; if (dut.credit_q[0] !== CREDIT_W'(1)) begin tests_failed++; $display("FAIL ce_coincident got %0d exp 1", dut.credit_q[0]); end
        set_req(0, 1'b0, '0);
        credit_in = {1'b1, 1'b1};
        repeat (4) tick();
        tests_run++; if (dut.credit_q[1] !== CREDIT_W'(4) || credit_err !== 1'b0) begin tests_failed++; $display("FAIL ce_refill got cred=%0d err=%b exp cred=4 err=0", dut.credit_q[1], credit_err); end
        tick();
        tests_run++; if (dut.credit_q[1] !== CREDIT_W'(4)) begin tests_failed++; $display("FAIL ce_sat got %0d exp 4", dut.credit_q[1]); end
        tests_run++; if (credit_err !== 1'b1) begin tests_failed++; $display("FAIL ce_err got %b exp 1", credit_err); end
        credit_in = '0;
        repeat (2) tick();
        tests_run++; if (credit_err !== 1'b1) begin tests_failed++; $display("FAIL ce_err_sticky got %b exp 1", credit_err); end
    endtask

    task automatic test_reset_locked();
        set_req(2, 1'b1, mk(1'b0, 2'd2, 1'b1, DW'(32'h60)));
        #1;
        tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL rl_ready0 got %b exp 0100", req_ready); end
        tick();
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rl_busy got %b exp 1", busy); end
        set_req(2, 1'b1, mk(1'b0, 2'd0, 1'b0, DW'(32'h61)));
        tick();
        tests_run++; if (send_flit_out !== {1'b1, mk(1'b0, 2'd2, 1'b1, DW'(32'h61))}) begin tests_failed++; $display("FAIL rl_body got %h exp %h", send_flit_out, {1'b1, mk(1'b0, 2'd2, 1'b1, DW'(32'h61))}); end
        reset = 1'b1;
        set_req(0, 1'b1, mk(1'b1, 2'd1, 1'b0, DW'(32'h70)));
        set_req(2, 1'b1, mk(1'b1, 2'd0, 1'b0, DW'(32'h62)));
        #1;
        tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL rl_ready_rst got %b exp 0000", req_ready); end
        tick();
        tests_run++; if (busy !== 1'b0 || send_flit_en !== 1'b0 || send_flit_out !== '0) begin tests_failed++; $display("FAIL rl_state got busy=%b en=%b out=%h exp 0/0/0", busy, send_flit_en, send_flit_out); end
        tests_run++; if (dut.credit_q[0] !== CREDIT_W'(4) || dut.credit_q[1] !== CREDIT_W'(4)) begin tests_failed++; $display("FAIL rl_creds got %0d/%0d exp 4/4", dut.credit_q[0], dut.credit_q[1]); end
        tests_run++; if (dut.rr_ptr_q !== 2'd0 || credit_err !== 1'b0) begin tests_failed++; $display("FAIL rl_rr_err got rr=%0d err=%b exp 0/0", dut.rr_ptr_q, credit_err); end
        reset = 1'b0;
        #1;
        tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL rl_first got %b exp 0001", req_ready); end
        tick();
        tests_run++; if (send_flit_out !== {1'b1, mk(1'b1, 2'd1, 1'b0, DW'(32'h70))}) begin tests_failed++; $display("FAIL rl_out got %h exp %h", send_flit_out, {1'b1, mk(1'b1, 2'd1, 1'b0, DW'(32'h70))}); end
        req_valid = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_two_flit();
        test_no_interleave();
        test_credit_block();
        test_credit_edges();
        test_reset_locked();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
